// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter run-command sequencer.
package counter_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CLEAR  = 2'b01,
        RUN    = 2'b10,
        SETTLE = 2'b11
    } state_t;

endpackage

// File: rtl/counter.sv
// 4-bit up counter with synchronous reset, count enable and wrap-around.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_shadow.sv
// Shadow model of the external counter; flags any divergence of its output.
// Only instantiated when COUNTER_SEQ_CHECK_EN is defined.
module counter_shadow #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_reset,
    input  logic             cnt_enable,
    input  logic             check_win,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             err
);

    logic [WIDTH-1:0] shadow;
    logic             shadow_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (cnt_reset) begin
                shadow       <= '0;
                shadow_valid <= 1'b1;
            end else if (cnt_enable) begin
                shadow <= shadow + 1'b1;
            end
            // Until the first clear the counter value is unknown, so no check.
            if (shadow_valid && check_win && (cnt_count != shadow)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_seq.sv
// Command-driven run sequencer for the external up counter.
// Define COUNTER_SEQ_CHECK_EN to build in the shadow checker driving err.
module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_clear,
    output logic             cnt_reset,
    output logic             cnt_enable,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == SETTLE);
            if (state == SETTLE) begin
                result <= cnt_count;
            end
            // Length is latched at accept; later cmd_len changes are ignored.
            if (accept) begin
                remaining <= cmd_len;
            end else if (state == RUN) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_clear) begin
                        state_nxt = CLEAR;
                    end else if (cmd_len != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = SETTLE;
                    end
                end
            end
            CLEAR: begin
                state_nxt = (remaining != '0) ? RUN : SETTLE;
            end
            RUN: begin
                if (remaining == LEN_W'(1)) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counter controls decode straight from the state register.
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign cnt_reset  = (state == CLEAR);
    assign cnt_enable = (state == RUN);

`ifdef COUNTER_SEQ_CHECK_EN
    logic check_win;

    assign check_win = (state == RUN) || (state == SETTLE);

    counter_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .check_win  (check_win),
        .cnt_count  (cnt_count),
        .err        (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq driving a real counter, with a result scoreboard.
module tb_counter_seq;
    import counter_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
`ifdef COUNTER_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_clear = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_ready;
    logic             cnt_reset;
    logic             cnt_enable;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] cnt_count_raw;
    logic [WIDTH-1:0] cnt_count;
    logic [WIDTH-1:0] result;
    logic             stuck = 1'b0;

    // stuck overrides what the sequencer sees, emulating a broken counter
    assign cnt_count = stuck ? 4'd2 : cnt_count_raw;

    always #5 clk = ~clk;

    counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (cnt_reset),
        .enable (cnt_enable),
        .count  (cnt_count_raw)
    );

    counter_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_clear  (cmd_clear),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .cnt_count  (cnt_count),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        bit               clr;
        int               len;
        logic             e;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] model_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns just after the accept edge.
    task automatic send(input bit clr, input int len, input bit push);
        check("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_clear = clr;
        cmd_len   = len[LEN_W-1:0];
        if (push) begin
            if (clr) model_cnt = '0;
            model_cnt = model_cnt + len[WIDTH-1:0];
            sb.push_back('{res: model_cnt, lat: (clr ? len + 3 : len + 2), clr: clr, len: len, e: 1'b0});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_clear = ~clr;
        cmd_len   = 8'h77;
    endtask

    // Follows one command cycle by cycle; returns at the negedge of its done cycle.
    task automatic wait_done(input string tag);
        exp_t e;
        int   k;
        int   n_rst = 0;
        int   n_en = 0;
        int   first_en = -1;
        int   last_en = -1;
        int   rst_cyc = -1;
        bit   both = 1'b0;
        bit   got = 1'b0;
        e = sb.pop_front();
        for (k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (cnt_reset) begin
                n_rst++;
                rst_cyc = k;
            end
            if (cnt_enable) begin
                n_en++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (cnt_reset && cnt_enable) both = 1'b1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_latency"}, k, e.lat);
        check({tag, "_result"}, {28'd0, result}, {28'd0, e.res});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e.e});
        check({tag, "_enable_cycles"}, n_en, e.len);
        check({tag, "_reset_cycles"}, n_rst, e.clr ? 1 : 0);
        check({tag, "_reset_and_enable"}, {31'd0, both}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (e.clr) check({tag, "_reset_cycle"}, rst_cyc, 1);
        if (e.len > 0) begin
            check({tag, "_first_enable"}, first_en, e.clr ? 2 : 1);
            check({tag, "_last_enable"}, last_en, e.clr ? e.len + 1 : e.len);
        end
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cnt_reset", {31'd0, cnt_reset}, 32'd0);
        check("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
        reset = 1'b0;

        send(1'b1, 5, 1'b1);
        wait_done("clr_len5");
        send(1'b0, 3, 1'b1);
        wait_done("b2b_len3");
        send(1'b1, 20, 1'b1);
        wait_done("clr_len20_wrap");
        send(1'b0, 0, 1'b1);
        wait_done("noclr_len0");
        send(1'b1, 0, 1'b1);
        wait_done("clr_len0");

        // Reset in the third RUN cycle of a clear, len=10 run.
        send(1'b1, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_in_run", {31'd0, cnt_enable}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_enable", {31'd0, cnt_enable}, 32'd0);
        check("mid_cnt_reset", {31'd0, cnt_reset}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_result", {28'd0, result}, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("mid_no_done_after", {31'd0, seen}, 32'd0);
        model_cnt = 4'd3;
        send(1'b0, 1, 1'b1);
        wait_done("after_mid_reset_len1");

        // Counter output stuck at 2 during a clear, len=6 run.
        stuck = 1'b1;
        send(1'b1, 6, 1'b0);
        sb.push_back('{res: 4'd2, lat: 9, clr: 1'b1, len: 6, e: CHK});
        wait_done("stuck_len6");
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("stuck_err_sticky", {31'd0, err}, {31'd0, CHK});
        check("stuck_result_hold", {28'd0, result}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("err_cleared_by_reset", {31'd0, err}, 32'd0);
        model_cnt = 4'd6;
        send(1'b0, 2, 1'b1);
        wait_done("post_stuck_len2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
